// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier, radix-2 or radix-4 chosen at elaboration.
// Datapath: A/Q/q_1 shift chain, M register, add/sub unit, IDLE/CALC control.
module booth_mult_seq #(
  parameter int WIDTH  = 4,
  parameter bit RADIX4 = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = RADIX4 ? WIDTH / 2 : WIDTH;
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = WIDTH + 2;
  localparam int SH   = RADIX4 ? 2 : 1;

  localparam logic [CW-1:0] ITER_C = CW'(ITER);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            q1_q, q1_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [2:0]      grp;
  logic            pos1, pos2;
  logic            neg1, neg2;
  logic [AW-1:0]   m2;
  logic [AW-1:0]   addend;
  logic            sub;
  logic [AW-1:0]   sum;
  logic signed [AW+WIDTH-1:0] aq_sh;

  // Radix-2 reuses the radix-4 table: {Q0,Q0,q_1} only hits 000/001/110/111.
  assign grp = RADIX4 ? {q_q[SH-1], q_q[0], q1_q}
                      : {q_q[0], q_q[0], q1_q};

  assign pos1 = (grp == 3'b001) || (grp == 3'b010);
  assign pos2 = (grp == 3'b011);
  assign neg2 = (grp == 3'b100);
  assign neg1 = (grp == 3'b101) || (grp == 3'b110);

  assign m2 = {m_q[AW-2:0], 1'b0};

  always_comb begin
    addend = '0;
    sub    = 1'b0;
    unique case (1'b1)
      pos1: addend = m_q;
      pos2: addend = m2;
      neg1: begin
        addend = m_q;
        sub    = 1'b1;
      end
      neg2: begin
        addend = m2;
        sub    = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum   = sub ? (a_q - addend) : (a_q + addend);
  assign aq_sh = $signed({sum, q_q}) >>> SH;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = ITER_C;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = aq_sh[AW+WIDTH-1:WIDTH];
        q_d   = aq_sh[WIDTH-1:0];
        q1_d  = q_q[SH-1];
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: three instances (W4 radix-2, W4 radix-4,
// W6 radix-4) sharing clk/reset, checked against a queue of expected products.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  start_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [3:0]  m0, q0, m1, q1;
  logic [5:0]  m2, q2;
  logic [7:0]  p0, p1;
  logic [11:0] p2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];

  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b0)) u_r2w4 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .multiplicand(m0), .multiplier(q0),
    .busy(busy_v[0]), .done(done_v[0]), .product(p0)
  );

  booth_mult_seq #(.WIDTH(4), .RADIX4(1'b1)) u_r4w4 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .multiplicand(m1), .multiplier(q1),
    .busy(busy_v[1]), .done(done_v[1]), .product(p1)
  );

  booth_mult_seq #(.WIDTH(6), .RADIX4(1'b1)) u_r4w6 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .multiplicand(m2), .multiplier(q2),
    .busy(busy_v[2]), .done(done_v[2]), .product(p2)
  );

  function automatic logic [11:0] prod(int d);
    case (d)
      0:       return {4'h0, p0};
      1:       return {4'h0, p1};
      default: return p2;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(int d, int m, int q);
    case (d)
      0: begin m0 = 4'(m); q0 = 4'(q); end
      1: begin m1 = 4'(m); q1 = 4'(q); end
      default: begin m2 = 6'(m); q2 = 6'(q); end
    endcase
  endtask

  task automatic go(int d, int m, int q);
    exp_t e;
    int   wd;
    int   p;
    wd  = (d == 2) ? 6 : 4;
    p   = m * q;
    e.d = d;
    e.v = 12'(p & ((1 << (2 * wd)) - 1));
    sb.push_back(e);
    drive_ops(d, m, q);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(int d, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (n < 40) begin
      if (busy_v[d]) bc++;
      if (done_v[d]) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(int d, int m, int q, int lat);
    int n, bc;
    go(d, m, q);
    wait_done(d, n, bc);
    chk($sformatf("latency_d%0d_m%0d_q%0d", d, m, q), n, lat);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (done_v[d]) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL spurious_done dut=%0d observed=done expected=none", d);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (e.d == d && prod(d) === e.v) else begin
            errors++;
            $error("FAIL product dut=%0d observed=%0h expected=%0h (dut %0d)",
                   d, prod(d), e.v, e.d);
          end
        end
      end
    end
  end

  initial begin
    int n, bc;
    reset   = 1'b1;
    start_v = '0;
    m0 = '0; q0 = '0; m1 = '0; q1 = '0; m2 = '0; q2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy_%0d", d), busy_v[d], 0);
      chk($sformatf("rst_done_%0d", d), done_v[d], 0);
      chk($sformatf("rst_prod_%0d", d), prod(d), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // 3 x -5, latency and busy width
    go(0, 3, -5);
    wait_done(0, n, bc);
    chk("lat_3x-5", n, 4);
    chk("busy_cycles_3x-5", bc, 4);
    @(posedge clk); #1;
    chk("done_pulse_width", done_v[0], 0);
    chk("prod_hold_idle", prod(0), 12'h0F1);

    run(0, -8, -8, 4);
    run(2, -32, 31, 3);
    run(2, -32, -32, 3);
    @(posedge clk); #1;

    // start while busy is ignored
    go(0, 2, 3);
    @(posedge clk); #1;
    drive_ops(0, 7, 7);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("busy_during_ignored", busy_v[0], 1);
    wait_done(0, n, bc);
    chk("lat_after_ignored", n, 2);

    // start in the done cycle is accepted
    go(0, -1, 1);
    chk("done_drop_on_restart", done_v[0], 0);
    chk("busy_on_restart", busy_v[0], 1);
    wait_done(0, n, bc);
    chk("lat_restart", n, 4);
    @(posedge clk); #1;

    // asynchronous reset during the second step
    go(0, 5, 3);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    chk("abort_prod", prod(0), 0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_v[0], 0);
    run(0, 5, 3, 4);
    run(1, -8, 7, 2);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int m = -8; m < 8; m++)
        for (int q = -8; q < 8; q++)
          run(d, m, q, (d == 0) ? 4 : 2);

    @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
